// File: rtl/dsp_chain_pkg.sv
// Shared constants and FSM state type for the fp16 DSP-chain feeder.
package dsp_chain_pkg;
  localparam int NUM_STAGES      = 4;
  localparam int PAIRS_PER_STAGE = 2;
  localparam int SLOTS           = 8;
  localparam int FP16_W          = 16;
  localparam int FP32_W          = 32;

  localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;
  localparam logic [FP32_W-1:0] FP32_ZERO = 32'h0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_ISSUE,
    ST_WAIT,
    ST_OUT
  } state_e;
endpackage

// File: rtl/dsp_skew_line.sv
// W-bit wide, DEPTH-deep shift register with synchronous active-low clear.
module dsp_skew_line #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         clear_n_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!clear_n_i) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[DEPTH-1];
endmodule

// File: rtl/dsp_chain_4_fp16_feeder.sv
// Packs an fp16 operand-pair stream into 8-slot passes for a 4-stage DSP chain,
// skews each stage's operands and carries the partial sum between passes.
module dsp_chain_4_fp16_feeder
  import dsp_chain_pkg::*;
#(
  parameter int STAGE_LAT  = 2,
  parameter int RESULT_LAT = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [FP16_W-1:0]       in_a,
  input  logic [FP16_W-1:0]       in_b,
  input  logic                    in_last,
  output logic [SLOTS*FP16_W-1:0] dsp_a,
  output logic [SLOTS*FP16_W-1:0] dsp_b,
  output logic [FP32_W-1:0]       dsp_fp32_in,
  input  logic [FP32_W-1:0]       chain_result,
  output logic                    out_valid,
  output logic [FP32_W-1:0]       out_data,
  input  logic                    out_ready
);
  localparam int STAGE_W = 2 * PAIRS_PER_STAGE * FP16_W;
  localparam int CNT_W   = $clog2(RESULT_LAT + 1);

  state_e              state_q;
  logic [FP16_W-1:0]   slot_a_q [SLOTS];
  logic [FP16_W-1:0]   slot_b_q [SLOTS];
  logic [2:0]          fill_cnt_q;
  logic                last_q;
  logic [FP32_W-1:0]   psum_q;
  logic [FP32_W-1:0]   out_data_q;
  logic                out_valid_q;
  logic [CNT_W-1:0]    wait_cnt_q;

  logic issue;
  logic hs;
  logic pass_done;

  assign issue     = (state_q == ST_ISSUE);
  assign in_ready  = (state_q == ST_FILL);
  assign hs        = in_valid && in_ready;
  assign pass_done = in_last || (fill_cnt_q == 3'(SLOTS - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      fill_cnt_q  <= '0;
      last_q      <= 1'b0;
      psum_q      <= FP32_ZERO;
      out_data_q  <= FP32_ZERO;
      out_valid_q <= 1'b0;
      wait_cnt_q  <= '0;
      for (int s = 0; s < SLOTS; s++) begin
        slot_a_q[s] <= FP16_ZERO;
        slot_b_q[s] <= FP16_ZERO;
      end
    end else begin
      case (state_q)
        ST_IDLE: state_q <= ST_FILL;
        ST_FILL: begin
          if (hs) begin
            // Slots past the final pair are padded so the chain adds zero products.
            for (int s = 0; s < SLOTS; s++) begin
              if (s == int'(fill_cnt_q)) begin
                slot_a_q[s] <= in_a;
                slot_b_q[s] <= in_b;
              end else if (pass_done && s > int'(fill_cnt_q)) begin
                slot_a_q[s] <= FP16_ZERO;
                slot_b_q[s] <= FP16_ZERO;
              end
            end
            fill_cnt_q <= fill_cnt_q + 3'd1;
            if (pass_done) begin
              last_q  <= in_last;
              state_q <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          wait_cnt_q <= CNT_W'(RESULT_LAT - 1);
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt_q == '0) begin
            fill_cnt_q <= '0;
            if (last_q) begin
              out_data_q  <= chain_result;
              out_valid_q <= 1'b1;
              psum_q      <= FP32_ZERO;
              state_q     <= ST_OUT;
            end else begin
              psum_q  <= chain_result;
              state_q <= ST_FILL;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q - 1'b1;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_FILL;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic [NUM_STAGES-1:0][STAGE_W-1:0] stage_in;
  logic [NUM_STAGES-1:0][STAGE_W-1:0] stage_out;

  // Stage word layout: {b_bot, b_top, a_bot, a_top}; stage k lags k*STAGE_LAT cycles.
  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
    assign stage_in[gi] = issue ? {slot_b_q[2*gi+1], slot_b_q[2*gi],
                                   slot_a_q[2*gi+1], slot_a_q[2*gi]} : '0;
    if (gi == 0) begin : g_direct
      assign stage_out[gi] = stage_in[gi];
    end else begin : g_skew
      dsp_skew_line #(
        .DEPTH(gi * STAGE_LAT),
        .W    (STAGE_W)
      ) u_skew (
        .clk      (clk),
        .clear_n_i(reset),
        .d_i      (stage_in[gi]),
        .q_o      (stage_out[gi])
      );
    end
    assign dsp_a[2*FP16_W*gi +: 2*FP16_W] = stage_out[gi][2*FP16_W-1:0];
    assign dsp_b[2*FP16_W*gi +: 2*FP16_W] = stage_out[gi][STAGE_W-1:2*FP16_W];
  end

  assign dsp_fp32_in = issue ? psum_q : FP32_ZERO;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
endmodule

// File: tb/tb_dsp_chain_4_fp16_feeder.sv
// Randomized bench for the DSP-chain feeder against a pass-level reference model.
module tb_dsp_chain_4_fp16_feeder;
  localparam int STAGE_LAT  = 2;
  localparam int RESULT_LAT = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  in_a;
  logic [15:0]  in_b;
  logic         in_last;
  logic [127:0] dsp_a;
  logic [127:0] dsp_b;
  logic [31:0]  dsp_fp32_in;
  logic [31:0]  chain_result;
  logic         out_valid;
  logic [31:0]  out_data;
  logic         out_ready;

  dsp_chain_4_fp16_feeder #(
    .STAGE_LAT (STAGE_LAT),
    .RESULT_LAT(RESULT_LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_last     (in_last),
    .dsp_a       (dsp_a),
    .dsp_b       (dsp_b),
    .dsp_fp32_in (dsp_fp32_in),
    .chain_result(chain_result),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] va [64];
  logic [15:0] vb [64];
  logic [31:0] sv [8];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Expected operand bus at a given cycle offset from the issue cycle.
  function automatic logic [127:0] exp_bus(input int base, input int n, input int off, input bit is_b);
    logic [127:0] r;
    r = '0;
    for (int s = 0; s < 8; s++) begin
      if (off == (s / 2) * STAGE_LAT && base + s < n)
        r[16*s +: 16] = is_b ? vb[base+s] : va[base+s];
    end
    return r;
  endfunction

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) begin
      va[i] = 16'($urandom);
      vb[i] = 16'($urandom);
    end
    for (int p = 0; p < 8; p++) sv[p] = $urandom | 32'h1;
  endtask

  task automatic feed_pass(input int base, input int n, input int gap);
    int cnt;
    cnt = (n - base > 8) ? 8 : n - base;
    for (int i = 0; i < cnt; i++) begin
      int idle;
      int w;
      idle = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
      repeat (idle) @(negedge clk);
      in_valid = 1'b1;
      in_a     = va[base+i];
      in_b     = vb[base+i];
      in_last  = (base + i == n - 1);
      if (i > 0) check("in_ready_fill", 128'(in_ready), 128'(1'b1));
      w = 0;
      while (!in_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) check("in_ready_timeout", 128'(in_ready), 128'(1'b1));
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    @(negedge clk);
    check("rst_dsp_a", dsp_a, 128'h0);
    check("rst_dsp_b", dsp_b, 128'h0);
    check("rst_fp32_in", 128'(dsp_fp32_in), 128'h0);
    check("rst_in_ready", 128'(in_ready), 128'h0);
    check("rst_out_valid", 128'(out_valid), 128'h0);
    check("rst_out_data", 128'(out_data), 128'h0);
    reset = 1'b1;
    repeat (RESULT_LAT + 4) begin
      chain_result = $urandom;
      @(negedge clk);
      check("no_stale_out", 128'(out_valid), 128'h0);
    end
  endtask

  // Called in the issue cycle; walks the skew window and the result capture.
  task automatic check_pass(input int base, input int n, input logic [31:0] psum,
                            input logic [31:0] stub, input int abort_at);
    for (int off = 0; off <= RESULT_LAT; off++) begin
      if (off == abort_at) begin
        reset_pulse();
        return;
      end
      check($sformatf("dsp_a@%0d", off), dsp_a, exp_bus(base, n, off, 1'b0));
      check($sformatf("dsp_b@%0d", off), dsp_b, exp_bus(base, n, off, 1'b1));
      check($sformatf("fp32_in@%0d", off), 128'(dsp_fp32_in), 128'(off == 0 ? psum : 32'h0));
      check("out_valid_busy", 128'(out_valid), 128'h0);
      if (off == 0) check("in_ready_issue", 128'(in_ready), 128'h0);
      chain_result = (off == RESULT_LAT) ? stub : $urandom;
      @(negedge clk);
    end
    chain_result = $urandom;
    if (base + 8 >= n) begin
      check("out_valid", 128'(out_valid), 128'(1'b1));
      check("out_data", 128'(out_data), 128'(stub));
    end else begin
      check("out_valid_mid", 128'(out_valid), 128'h0);
      check("next_fill", 128'(in_ready), 128'(1'b1));
    end
  endtask

  task automatic run_vector(input int n, input int gap, input int hold,
                            input int abort_pass, input int abort_off);
    logic [31:0] psum;
    int passes;
    psum   = 32'h0;
    passes = (n + 7) / 8;
    for (int p = 0; p < passes; p++) begin
      feed_pass(8 * p, n, gap);
      if (p == abort_pass) begin
        check_pass(8 * p, n, psum, sv[p], abort_off);
        $display("vector n=%0d aborted by reset in pass %0d", n, p);
        return;
      end
      check_pass(8 * p, n, psum, sv[p], -1);
      psum = sv[p];
    end
    repeat (hold) begin
      out_ready = 1'b0;
      @(negedge clk);
      check("hold_valid", 128'(out_valid), 128'(1'b1));
      check("hold_data", 128'(out_data), 128'(sv[passes-1]));
      check("hold_in_ready", 128'(in_ready), 128'h0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", 128'(out_valid), 128'h0);
    check("fill_resume", 128'(in_ready), 128'(1'b1));
    $display("vector n=%0d passes=%0d result=%h hold=%0d", n, passes, sv[passes-1], hold);
  endtask

  initial begin
    reset        = 1'b0;
    in_valid     = 1'b0;
    in_a         = '0;
    in_b         = '0;
    in_last      = 1'b0;
    chain_result = '0;
    out_ready    = 1'b0;
    repeat (3) @(negedge clk);
    check("init_dsp_a", dsp_a, 128'h0);
    check("init_dsp_b", dsp_b, 128'h0);
    check("init_fp32_in", 128'(dsp_fp32_in), 128'h0);
    check("init_in_ready", 128'(in_ready), 128'h0);
    check("init_out_valid", 128'(out_valid), 128'h0);
    check("init_out_data", 128'(out_data), 128'h0);
    reset = 1'b1;
    @(negedge clk);

    // Single full pass: 1.0 * 2.0 x8, last on the 8th pair.
    for (int i = 0; i < 8; i++) begin
      va[i] = 16'h3C00;
      vb[i] = 16'h4000;
    end
    sv[0] = 32'h41800000;
    run_vector(8, 0, 0, -1, -1);

    // Short vector with padding.
    fill_rand(3);
    run_vector(3, 0, 1, -1, -1);

    // Two passes with backpressure on the result.
    fill_rand(12);
    sv[0] = 32'h41000000;
    run_vector(12, 0, 5, -1, -1);

    // Gaps between handshakes.
    fill_rand(8);
    run_vector(8, 3, 2, -1, -1);

    // Reset during the second pass's wait, then a clean vector.
    fill_rand(12);
    run_vector(12, 0, 0, 1, 4);
    fill_rand(12);
    run_vector(12, 1, 1, -1, -1);

    for (int v = 0; v < 6; v++) begin
      int n;
      n = int'($urandom_range(20, 1));
      fill_rand(n);
      run_vector(n, int'($urandom_range(2, 0)), int'($urandom_range(4, 0)), -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/dsp_chain_4_fp16_feeder.md
Name: dsp_chain_4_fp16_feeder

Overview:
- Producer-side sequencer for a 4-stage fp16 sum-of-2-products DSP cascade (8 products per pass, chainin→chainout linked, fp32 result from stage 4).
- Accepts an operand-pair stream for one dot product and packs it into 8-pair passes. Applies per-stage input skew, injects the previous pass's partial sum on stage-1 fp32_in, and returns the final fp32 dot product on a valid/ready output.
- Sits between the operand memories/streamers and the DSP chain instance.

Parameters:
- STAGE_LAT, 2, cycles between stage k and stage k+1 operand consumption; operands for stage k (k=0..3) are delayed k*STAGE_LAT cycles.
- RESULT_LAT, 8, cycles from the stage-0 issue cycle to chain_result being valid; must be >= 3*STAGE_LAT+1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  feeder can accept a pair
- in_a  in  16  fp16 operand a
- in_b  in  16  fp16 operand b
- in_last  in  1  final pair of the current dot product
- dsp_a  out  128  slot s=2k+j (k = stage 0..3, j = 0 top / 1 bot) at bits [16s+15:16s]
- dsp_b  out  128  same slot layout as dsp_a
- dsp_fp32_in  out  32  partial sum to stage-0 fp32_in
- chain_result  in  32  stage-3 result from the chain
- out_valid  out  1  dot product available
- out_data  out  32  fp32 dot product
- out_ready  in  1  consumer accepts out_data

Behaviour:
- Reset (reset==0 at a clk edge) values:
  - in_ready=0, out_valid=0, out_data=0, dsp_a=0, dsp_b=0, dsp_fp32_in=0.
  - All skew registers and counters cleared; state=IDLE; partial-sum register=0.
  - Reset mid-pass abandons all work; a chain_result arriving later is ignored.
- States: IDLE, FILL, ISSUE, WAIT, OUT.
  - IDLE→FILL on the first cycle after reset. in_ready=1 only in FILL.
  - FILL: each in_valid&&in_ready handshake writes the pair into slot fill_cnt (3-bit counter, 0..7), then fill_cnt increments.
    - Handshake at fill_cnt==7 or with in_last=1 → ISSUE, with remaining slots zero-padded (16'h0000).
    - The last flag is latched.
  - ISSUE, exactly 1 cycle:
    - Stage-0 slots drive dsp_a/dsp_b this cycle.
    - Stage k slots drive their outputs exactly k*STAGE_LAT cycles later, each for one cycle.
    - Outside its own drive cycle, each slot field is 0.
    - dsp_fp32_in = partial-sum register during the ISSUE cycle, 0 otherwise.
    - A RESULT_LAT down-counter loads; state → WAIT.
  - WAIT: on counter expiry, capture chain_result (the cycle exactly RESULT_LAT after ISSUE).
    - If latched last==0: partial-sum register = chain_result, fill_cnt=0 → FILL (next pass).
    - If latched last==1: out_data = chain_result, out_valid=1, partial-sum register cleared → OUT.
  - OUT: hold out_valid/out_data stable until out_valid&&out_ready; then out_valid=0 → FILL.
- One pass in flight; the skew pipeline fully drains before the next ISSUE, since the WAIT time covers the 3*STAGE_LAT skew.
- First pass of every dot product uses partial sum 0.
- No fp arithmetic in this block; fp values pass through bit-exact.
- in_last on a pair that is exactly the 8th: no padding, single ISSUE.
- Empty dot product is not possible: each vector has at least one pair.
- Throughput for N pairs: ceil(N/8) passes, each at least (pairs+1+RESULT_LAT) cycles.

Decomposition:
- Shared package dsp_chain_pkg:
  - NUM_STAGES=4, PAIRS_PER_STAGE=2, SLOTS=8, FP16_W=16, FP32_W=32.
  - FP16_ZERO=16'h0000, FP32_ZERO=32'h0.
  - State enum.
- One natural sub-module: dsp_skew_line (parameter DEPTH), a 64-bit wide, DEPTH-deep shift register with synchronous active-low clear. Instantiated for stages 1..3 with DEPTH = k*STAGE_LAT.

Test Plan:
- Single pass: 8 pairs a=16'h3C00 (1.0), b=16'h4000 (2.0), last on the 8th; chain stub returns 32'h41800000.
  - ISSUE cycle: stage-0 slots = 3C00/4000.
  - Stage 3 slots appear at +6 cycles.
  - out_valid with out_data=32'h41800000 at ISSUE+RESULT_LAT+1.
- Short vector: 3 pairs, last on the 3rd. Slots 0-2 loaded; slots 3-7 = 0000 on their drive cycles; dsp_fp32_in=0 at ISSUE.
- Multi-pass: 12 pairs; stub returns 32'h41000000 on pass 1.
  - Pass-2 ISSUE drives dsp_fp32_in=32'h41000000.
  - Pass-2 slots 4-7 are zero.
  - Exactly one out_valid.
- Backpressure: out_ready held 0 for 5 cycles. out_valid/out_data stable throughout; in_ready=0 until the accepting cycle; FILL resumes next cycle.
- Reset mid-WAIT: reset low 1 cycle during WAIT.
  - All outputs 0; no out_valid produced from the stale chain_result.
  - Next vector behaves as a clean first pass.
- in_valid gaps: pairs with idle cycles between them. Slot order preserved; ISSUE occurs only after the 8th handshake.
